// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle datapath controller: opcode constants,
// ALUop encodings, operand/PC mux selects, the FSM state enum and the control
// vector driven by the output decoder.
package multi_cycle_ctrl_pkg;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // ALUop to the ALU controller
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU operand-B select
    localparam logic [1:0] AluBReg      = 2'b00;
    localparam logic [1:0] AluBFour     = 2'b01;
    localparam logic [1:0] AluBImm      = 2'b10;
    localparam logic [1:0] AluBImmShift = 2'b11;

    // Next-PC select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StRWb,
        StExecI,
        StIWb,
        StBranch,
        StJump
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    localparam int unsigned CtrlW = $bits(ctrl_t);

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OpRType) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpAddi) || (op == OpJ);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational mapping from controller state (plus memory handshake) to the
// datapath control vector. Anything not set for a state stays 0.
// Ports:
//   state_i     - current FSM state (state_e encoding)
//   mem_ready_i - memory completes this cycle (already gated by reset)
//   ctrl_o      - packed ctrl_t control vector
module ctrl_out_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [3:0]       state_i,
    input  logic             mem_ready_i,
    output logic [CtrlW-1:0] ctrl_o
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        unique case (state_e'(state_i))
            StFetch: begin
                w_ctrl.mem_read = 1'b1;
                if (mem_ready_i) begin
                    // Latch the instruction and advance PC by 4 in the same cycle
                    w_ctrl.ir_write  = 1'b1;
                    w_ctrl.pc_write  = 1'b1;
                    w_ctrl.alu_src_b = AluBFour;
                    w_ctrl.alu_op    = AluOpAdd;
                    w_ctrl.pc_source = PcSrcAlu;
                end
            end
            StDecode: begin
                // Speculatively compute the branch target
                w_ctrl.alu_src_b = AluBImmShift;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemAddr: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluBImm;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.i_or_d     = 1'b1;
                w_ctrl.instr_done = mem_ready_i;
            end
            StExecR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluBReg;
                w_ctrl.alu_op    = AluOpFunct;
            end
            StRWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            StExecI: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = AluBImm;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StIWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            StBranch: begin
                // Datapath qualifies pc_write_cond with the ALU zero flag
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = AluBReg;
                w_ctrl.alu_op        = AluOpSub;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PcSrcAluOut;
                w_ctrl.instr_done    = 1'b1;
            end
            StJump: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PcSrcJump;
                w_ctrl.instr_done = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign ctrl_o = w_ctrl;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style main controller: sequences FETCH/DECODE/execute/
// writeback states and drives datapath strobes and mux selects.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   opcode_i              - IR opcode field (sampled in DECODE and MEM_ADDR)
//   mem_ready_i           - memory access completes this cycle
//   zero_i                - ALU zero flag (consumed by the datapath's PC gate)
//   *_o strobes/selects   - datapath controls, alu_op_o to the ALU controller
//   instr_done_o          - pulse when an instruction retires
//   illegal_o             - pulse in DECODE for an unsupported opcode
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       i_or_d_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_mem_ready;
    logic [CtrlW-1:0] w_ctrl_vec;
    ctrl_t            w_ctrl;
    logic             w_unused;

    // Branch resolution happens in the datapath (pc_write_cond & zero)
    assign w_unused = zero_i;

    // Reset holds outputs at the FETCH-wait pattern even if memory reports ready
    assign w_mem_ready = mem_ready_i & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFetch:   if (mem_ready_i) w_state_next = StDecode;
            StDecode: begin
                case (opcode_i)
                    OpLw, OpSw: w_state_next = StMemAddr;
                    OpRType:    w_state_next = StExecR;
                    OpAddi:     w_state_next = StExecI;
                    OpBeq:      w_state_next = StBranch;
                    OpJ:        w_state_next = StJump;
                    default:    w_state_next = StFetch;
                endcase
            end
            StMemAddr: w_state_next = (opcode_i == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready_i) w_state_next = StMemWb;
            StMemWb:   w_state_next = StFetch;
            StMemWr:   if (mem_ready_i) w_state_next = StFetch;
            StExecR:   w_state_next = StRWb;
            StRWb:     w_state_next = StFetch;
            StExecI:   w_state_next = StIWb;
            StIWb:     w_state_next = StFetch;
            StBranch:  w_state_next = StFetch;
            StJump:    w_state_next = StFetch;
            default:   w_state_next = StFetch;
        endcase
    end

    ctrl_out_decode u_ctrl_out_decode (
        .state_i     (r_state),
        .mem_ready_i (w_mem_ready),
        .ctrl_o      (w_ctrl_vec)
    );

    assign w_ctrl = ctrl_t'(w_ctrl_vec);

    assign pc_write_o      = w_ctrl.pc_write;
    assign pc_write_cond_o = w_ctrl.pc_write_cond;
    assign ir_write_o      = w_ctrl.ir_write;
    assign mem_read_o      = w_ctrl.mem_read;
    assign mem_write_o     = w_ctrl.mem_write;
    assign i_or_d_o        = w_ctrl.i_or_d;
    assign reg_write_o     = w_ctrl.reg_write;
    assign reg_dst_o       = w_ctrl.reg_dst;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign alu_src_a_o     = w_ctrl.alu_src_a;
    assign alu_src_b_o     = w_ctrl.alu_src_b;
    assign alu_op_o        = w_ctrl.alu_op;
    assign pc_source_o     = w_ctrl.pc_source;
    assign instr_done_o    = w_ctrl.instr_done;
    assign illegal_o       = (r_state == StDecode) && !op_is_legal(opcode_i);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: a step-within-instruction model predicts every
// output on each falling edge; directed runs add literal expectations.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] R_OP = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    bit         clk;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic       zero_i;
    logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o;
    logic       i_or_d_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
    logic       instr_done_o, illegal_o;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .opcode_i        (opcode_i),
        .mem_ready_i     (mem_ready_i),
        .zero_i          (zero_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .ir_write_o      (ir_write_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .i_or_d_o        (i_or_d_o),
        .reg_write_o     (reg_write_o),
        .reg_dst_o       (reg_dst_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .pc_source_o     (pc_source_o),
        .instr_done_o    (instr_done_o),
        .illegal_o       (illegal_o)
    );

    outs_t act;
    assign act = {pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o,
                  reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                  pc_source_o, instr_done_o, illegal_o};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, a, e);
        end
    endtask

    // ---------------- model: instruction class + step number ----------------
    function automatic logic legal(input logic [5:0] op);
        return op == R_OP || op == LW || op == SW || op == BEQ || op == ADDI || op == JMP;
    endfunction

    // Cycles from fetch to retire, memory waits excluded
    function automatic int lat(input logic [5:0] op);
        if (op == LW) return 5;
        if (op == SW || op == R_OP || op == ADDI) return 4;
        if (op == BEQ || op == JMP) return 3;
        return 2;
    endfunction

    function automatic logic waits_mem(input int step, input logic [5:0] op);
        return step == 0 || (step == 3 && (op == LW || op == SW));
    endfunction

    function automatic outs_t exp_outs(input int step, input logic [5:0] op, input logic rdy,
                                       input logic in_rst);
        outs_t e;
        e = '0;
        if (in_rst) begin
            e.mem_read = 1'b1;
        end else if (step == 0) begin
            e.mem_read = 1'b1;
            if (rdy) begin
                e.ir_write  = 1'b1;
                e.pc_write  = 1'b1;
                e.alu_src_b = 2'b01;
            end
        end else if (step == 1) begin
            e.alu_src_b = 2'b11;
            e.illegal   = !legal(op);
        end else if ((op == LW || op == SW) && step == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
        end else if (op == LW && step == 3) begin
            e.mem_read = 1'b1;
            e.i_or_d   = 1'b1;
        end else if (op == LW && step == 4) begin
            e.reg_write  = 1'b1;
            e.mem_to_reg = 1'b1;
            e.instr_done = 1'b1;
        end else if (op == SW && step == 3) begin
            e.mem_write  = 1'b1;
            e.i_or_d     = 1'b1;
            e.instr_done = rdy;
        end else if (op == R_OP && step == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_op    = 2'b10;
        end else if (op == R_OP && step == 3) begin
            e.reg_write  = 1'b1;
            e.reg_dst    = 1'b1;
            e.instr_done = 1'b1;
        end else if (op == ADDI && step == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
        end else if (op == ADDI && step == 3) begin
            e.reg_write  = 1'b1;
            e.instr_done = 1'b1;
        end else if (op == BEQ && step == 2) begin
            e.alu_src_a     = 1'b1;
            e.alu_op        = 2'b01;
            e.pc_write_cond = 1'b1;
            e.pc_source     = 2'b01;
            e.instr_done    = 1'b1;
        end else if (op == JMP && step == 2) begin
            e.pc_write   = 1'b1;
            e.pc_source  = 2'b10;
            e.instr_done = 1'b1;
        end
        return e;
    endfunction

    int         m_step = 0;
    logic [5:0] m_op   = '0;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_step <= 0;
            m_op   <= '0;
        end else if (m_step == 1) begin
            m_op   <= opcode_i;
            m_step <= legal(opcode_i) ? 2 : 0;
        end else if (!(waits_mem(m_step, m_op) && !mem_ready_i)) begin
            if (m_step != 0 && m_step == lat(m_op) - 1) m_step <= 0;
            else m_step <= m_step + 1;
        end
    end

    always @(negedge clk) begin
        outs_t e;
        e = exp_outs(m_step, (m_step == 1) ? opcode_i : m_op, mem_ready_i, rst_i);
        chk($sformatf("model_t%0t", $time), 32'(act), 32'(e));
    end

    // ---------------- directed stimulus ----------------
    outs_t cap[16];

    // Cycle i drives opcode/ready at posedge+1, captures outputs at the falling edge
    task automatic run_cycles(input logic [5:0] op, input logic [15:0] rdy, input int n,
                              input logic garble);
        for (int i = 0; i < n; i++) begin
            opcode_i    = (garble && i >= 2) ? BAD : op;
            mem_ready_i = rdy[i];
            @(negedge clk);
            cap[i] = act;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        outs_t e_wait;
        e_wait          = '0;
        e_wait.mem_read = 1'b1;
        rst_i       = 1'b1;
        opcode_i    = '0;
        mem_ready_i = 1'b1;
        zero_i      = 1'b0;
        #2;
        chk("reset_outs", 32'(act), 32'(e_wait));
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // LW, memory always ready
        run_cycles(LW, 16'hFFFF, 5, 1'b0);
        chk("lw_done_only_c5", 32'({cap[4].instr_done, cap[3].instr_done, cap[2].instr_done,
                                    cap[1].instr_done, cap[0].instr_done}), 32'(5'b10000));
        chk("lw_memaddr_b", 32'(cap[2].alu_src_b), 32'(2'b10));
        chk("lw_memrd", 32'({cap[3].mem_read, cap[3].i_or_d}), 32'(2'b11));
        chk("lw_wb", 32'({cap[4].reg_write, cap[4].mem_to_reg, cap[4].reg_dst}), 32'(3'b110));

        // BEQ taken then not taken: controller outputs identical
        zero_i = 1'b1;
        run_cycles(BEQ, 16'hFFFF, 3, 1'b0);
        chk("beq_z1_c3", 32'({cap[2].pc_write_cond, cap[2].pc_source, cap[2].instr_done}),
            32'(4'b1011));
        zero_i = 1'b0;
        run_cycles(BEQ, 16'hFFFF, 3, 1'b0);
        chk("beq_z0_c3", 32'({cap[2].pc_write_cond, cap[2].pc_source, cap[2].instr_done}),
            32'(4'b1011));
        chk("beq_aluop", 32'(cap[2].alu_op), 32'(2'b01));

        // J after a 3-cycle fetch stall
        run_cycles(JMP, 16'b111000, 6, 1'b0);
        chk("fetch_rd_held", 32'({cap[3].mem_read, cap[2].mem_read, cap[1].mem_read,
                                  cap[0].mem_read}), 32'(4'b1111));
        chk("fetch_ir_once", 32'({cap[3].ir_write, cap[2].ir_write, cap[1].ir_write,
                                  cap[0].ir_write}), 32'(4'b1000));
        chk("jump_c", 32'({cap[5].pc_write, cap[5].pc_source, cap[5].instr_done}),
            32'(4'b1101));

        // Illegal opcode: back to FETCH with no architectural writes
        run_cycles(BAD, 16'b011, 3, 1'b0);
        chk("illegal_pulse", 32'({cap[1].illegal, cap[0].illegal, cap[2].illegal}),
            32'(3'b100));
        chk("illegal_no_wr", 32'({cap[1].reg_write, cap[1].mem_write, cap[1].pc_write,
                                  cap[2].reg_write, cap[2].mem_write, cap[2].pc_write}),
            32'(6'b0));
        chk("illegal_fetch", 32'({cap[2].mem_read, cap[2].i_or_d}), 32'(2'b10));

        // R-type then ADDI; opcode garbage after decode must not matter
        run_cycles(R_OP, 16'hFFFF, 4, 1'b1);
        chk("r_aluop", 32'(cap[2].alu_op), 32'(2'b10));
        chk("r_wb", 32'({cap[3].reg_write, cap[3].reg_dst, cap[3].instr_done}), 32'(3'b111));
        run_cycles(ADDI, 16'hFFFF, 4, 1'b1);
        chk("addi_alu", 32'({cap[2].alu_op, cap[2].alu_src_b}), 32'(4'b0010));
        chk("addi_wb", 32'({cap[3].reg_write, cap[3].reg_dst, cap[3].instr_done}),
            32'(3'b101));

        // SW stuck waiting on memory, then asynchronous reset mid-cycle
        run_cycles(SW, 16'b00111, 5, 1'b0);
        chk("sw_wait", 32'({cap[3].mem_write, cap[3].i_or_d, cap[3].instr_done}),
            32'(3'b110));
        #2;
        chk("sw_still_wr", 32'(mem_write_o), 32'(1'b1));
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        chk("rst_async_wr", 32'({mem_write_o, mem_read_o, ir_write_o, instr_done_o}),
            32'(4'b0100));
        chk("rst_outs", 32'(act), 32'(e_wait));
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Fetch starts on the first edge after reset release
        run_cycles(LW, 16'hFFFF, 5, 1'b0);
        chk("post_rst_fetch", 32'({cap[0].ir_write, cap[4].instr_done}), 32'(2'b11));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port opcode_i, input, 6: opcode field of the instruction register (IR).
REQ-004 SHALL have port mem_ready_i, input, 1: memory completes the current read/write this cycle.
REQ-005 SHALL have port zero_i, input, 1: ALU zero flag, used for BEQ.
REQ-006 SHALL have ports pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, output, 1 each: datapath strobes and mux selects.
REQ-007 SHALL have ports alu_src_b_o, alu_op_o, pc_source_o, output, 2 each: ALU operand-B select, ALUop to the ALU controller, next-PC select.
REQ-008 SHALL have port instr_done_o, output, 1: one-cycle pulse when an instruction retires.
REQ-009 SHALL have port illegal_o, output, 1: one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-010 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
REQ-011 SHALL decode opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010; all others are illegal.
REQ-012 FETCH SHALL assert mem_read_o=1 and i_or_d_o=0 while waiting; on mem_ready_i=1 it SHALL assert ir_write_o, pc_write_o, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00 and pc_source_o=00, then go to DECODE.
REQ-013 FETCH SHALL hold with ir_write_o=0 and pc_write_o=0 while mem_ready_i=0.
REQ-014 DECODE SHALL drive alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00 (branch target).
REQ-015 DECODE SHALL branch by opcode: LW/SW->MEM_ADDR, R->EXEC_R, ADDI->EXEC_I, BEQ->BRANCH, J->JUMP, illegal->FETCH with illegal_o=1.
REQ-016 MEM_ADDR SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00, then go to MEM_RD for LW or MEM_WR for SW.
REQ-017 MEM_RD and MEM_WR SHALL hold mem_read_o or mem_write_o=1 with i_or_d_o=1 until mem_ready_i=1; MEM_RD then goes to MEM_WB, MEM_WR then goes to FETCH with instr_done_o=1.
REQ-018 MEM_WB SHALL assert reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0 and instr_done_o=1, then go to FETCH.
REQ-019 EXEC_R SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10; R_WB SHALL assert reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0 and instr_done_o=1.
REQ-020 EXEC_I SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00; I_WB SHALL assert reg_write_o=1, reg_dst_o=0 and instr_done_o=1.
REQ-021 BRANCH SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_write_cond_o=1, pc_source_o=01 and instr_done_o=1, then go to FETCH; the PC updates only if zero_i=1.
REQ-022 JUMP SHALL assert pc_write_o=1, pc_source_o=10 and instr_done_o=1, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0, so outputs are a pure function of state plus mem_ready_i.
REQ-024 Instruction latency SHALL be (excluding memory waits): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.
REQ-025 mem_ready_i SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-026 The opcode SHALL be sampled only in DECODE and MEM_ADDR.

Reset
REQ-027 rst_i=1 SHALL force state FETCH immediately and asynchronously, including mid-instruction or mid-memory-wait.
REQ-028 During reset all registered flags SHALL be 0 and every output SHALL take its FETCH-wait value: mem_read_o=1, all others 0.
REQ-029 On the first clock edge after rst_i deasserts, the block SHALL begin a fetch.

Structure
REQ-030 A shared package SHALL hold the opcode constants, the state enum and the ALUop constants (00 add, 01 sub, 10 funct).
REQ-031 SHALL contain one sub-module, ctrl_out_decode: combinational state/mem_ready_i to control-vector mapping.
REQ-032 alu_op_o SHALL feed the existing ALU controller unchanged.

Verification
REQ-033 Test: LW with mem_ready_i=1 every cycle -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; instr_done_o high only in cycle 5.
REQ-034 Test: BEQ with zero_i=1, then zero_i=0 -> pc_write_cond_o=1 and pc_source_o=01 in cycle 3 both times; instr_done_o pulses.
REQ-035 Test: FETCH with mem_ready_i low 3 cycles -> mem_read_o held 4 cycles; ir_write_o pulses once, in the 4th.
REQ-036 Test: opcode 111111 -> illegal_o=1 in DECODE; FETCH next; reg_write_o, mem_write_o and pc_write_o stay 0.
REQ-037 Test: rst_i pulsed mid MEM_WR wait -> mem_write_o drops to 0 without waiting for a clock; state FETCH; no instr_done_o.
REQ-038 Test: R-type then ADDI back-to-back -> alu_op_o=10 in EXEC_R and 00 in EXEC_I; reg_dst_o=1 then 0 in writeback.
